blood_match_scanner: RTL and testbench

//  Registered donor inventory of DEPTH units (ABO + Rh each) plus a sequential matcher.

---
 rtl/blood_match_scanner.sv | 118 +++++++++++
 tb/tb_blood_match_scanner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/blood_match_scanner.sv
// blood_match_scanner: registered donor inventory with a sequential first-compatible-unit matcher
module blood_match_scanner #(
    parameter int DEPTH       = 8,
    parameter int IDX_W       = $clog2(DEPTH),
    parameter bit EXACT_FIRST = 1'b1,
    parameter bit CONSUME     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_vld,
    input  logic             wr_a,
    input  logic             wr_b,
    input  logic             wr_rh,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             req_rh,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_exact,
    output logic [IDX_W:0]   inv_count
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_nxt;
    logic [DEPTH-1:0] ent_vld, ent_a, ent_b, ent_rh;
    logic [IDX_W-1:0] idx;
    logic pass, pa, pb, prh;
    logic cur_exact, cur_compat, hit, last, clr;
    always_comb begin
        cur_exact  = ent_vld[idx] & (ent_a[idx] == pa) & (ent_b[idx] == pb) & (ent_rh[idx] == prh);
        cur_compat = ent_vld[idx] & (!ent_a[idx] | pa) & (!ent_b[idx] | pb) & (!ent_rh[idx] | prh);
        hit        = pass ? cur_compat : cur_exact;
        last       = idx == IDX_W'(DEPTH - 1);
        clr        = CONSUME && state == DONE && rsp_ready && rsp_found;
    end
    always_comb begin
        inv_count = '0;
        for (int i = 0; i < DEPTH; i++) inv_count = inv_count + (IDX_W+1)'(ent_vld[i]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid ? SCAN : IDLE;
            SCAN:    state_nxt = (hit || (last && pass)) ? DONE : SCAN;
            DONE:    state_nxt = rsp_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pass      <= 1'b0;
            pa        <= 1'b0;
            pb        <= 1'b0;
            prh       <= 1'b0;
            rsp_found <= 1'b0;
            rsp_idx   <= '0;
            rsp_exact <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            pa   <= req_a;
            pb   <= req_b;
            prh  <= req_rh;
            idx  <= '0;
            pass <= !EXACT_FIRST;
        end else if (state == SCAN) begin
            if (hit) begin
                rsp_found <= 1'b1;
                rsp_idx   <= idx;
                rsp_exact <= !pass;
            end else if (last && pass) begin
                rsp_found <= 1'b0;
                rsp_idx   <= '0;
                rsp_exact <= 1'b0;
            end else if (last) begin
                pass <= 1'b1;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (state == DONE && rsp_ready) begin
            rsp_found <= 1'b0;
            rsp_idx   <= '0;
            rsp_exact <= 1'b0;
        end
    end
    // a write in the same cycle as a consume clear lands last and therefore wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
            ent_a   <= '0;
            ent_b   <= '0;
            ent_rh  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr && rsp_idx == IDX_W'(i)) ent_vld[i] <= 1'b0;
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    ent_vld[i] <= wr_vld;
                    ent_a[i]   <= wr_a;
                    ent_b[i]   <= wr_b;
                    ent_rh[i]  <= wr_rh;
                end
            end
        end
    end
endmodule

// File: tb/tb_blood_match_scanner.sv
// tb_blood_match_scanner: directed stimulus with a request-level reference model checked every cycle
`timescale 1ns/100ps
module tb_blood_match_scanner;
    localparam int D  = 8;
    localparam bit EF = 1'b1;
    logic clk = 1'b0, rst_n = 1'b0;
    logic wr_en = 0, wr_vld = 0, wr_a = 0, wr_b = 0, wr_rh = 0;
    logic [2:0] wr_idx = '0;
    logic req_valid = 0, req_a = 0, req_b = 0, req_rh = 0, rsp_ready = 0;
    logic req_ready, rsp_valid, rsp_found, rsp_exact;
    logic [2:0] rsp_idx;
    logic [3:0] inv_count;
    int checks = 0, errors = 0;

    blood_match_scanner dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_vld(wr_vld),
        .wr_a(wr_a), .wr_b(wr_b), .wr_rh(wr_rh), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rh(req_rh), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_found(rsp_found), .rsp_idx(rsp_idx), .rsp_exact(rsp_exact), .inv_count(inv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // reference model: the answer and its latency are decided at acceptance from the stored inventory
    typedef struct packed {logic f; logic [2:0] i; logic e; logic [31:0] l;} res_t;
    logic [D-1:0] m_vld, m_a, m_b, m_rh;
    int m_state, m_cnt;
    logic m_found, m_exact;
    logic [2:0] m_idx;

    function automatic res_t find(input logic pa, input logic pb, input logic prh);
        res_t r;
        logic ex, co;
        r = '0;
        r.l = EF ? 2 * D : D;
        for (int p = (EF ? 0 : 1); p < 2; p++)
            for (int k = 0; k < D; k++) begin
                ex = m_vld[k] && m_a[k] == pa && m_b[k] == pb && m_rh[k] == prh;
                co = m_vld[k] && (!m_a[k] || pa) && (!m_b[k] || pb) && (!m_rh[k] || prh);
                if (!r.f && (p == 0 ? ex : co)) begin
                    r.f = 1'b1;
                    r.i = 3'(k);
                    r.e = p == 0;
                    r.l = k + 1 + ((p == 1 && EF) ? D : 0);
                end
            end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= '0; m_a <= '0; m_b <= '0; m_rh <= '0;
            m_state <= 0; m_cnt <= 0; m_found <= 0; m_idx <= 0; m_exact <= 0;
        end else begin
            for (int i = 0; i < D; i++) begin
                if (m_state == 2 && rsp_ready && m_found && m_idx == 3'(i)) m_vld[i] <= 1'b0;
                if (wr_en && wr_idx == 3'(i)) begin
                    m_vld[i] <= wr_vld; m_a[i] <= wr_a; m_b[i] <= wr_b; m_rh[i] <= wr_rh;
                end
            end
            if (m_state == 0 && req_valid) begin
                res_t r;
                r = find(req_a, req_b, req_rh);
                m_found <= r.f; m_idx <= r.i; m_exact <= r.e; m_cnt <= int'(r.l); m_state <= 1;
            end else if (m_state == 1) begin
                if (m_cnt == 1) m_state <= 2;
                else m_cnt <= m_cnt - 1;
            end else if (m_state == 2 && rsp_ready) m_state <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_rsp_valid", rsp_valid, m_state == 2);
            chk("cyc_req_ready", req_ready, m_state == 0);
            chk("cyc_inv_count", inv_count, $countones(m_vld));
            if (m_state == 2) begin
                chk("cyc_rsp_found", rsp_found, m_found);
                chk("cyc_rsp_idx", rsp_idx, m_idx);
                chk("cyc_rsp_exact", rsp_exact, m_exact);
            end
        end
    end

    task automatic wr(input int i, input logic v, input logic a, input logic b, input logic rh);
        wr_idx = 3'(i); wr_vld = v; wr_a = a; wr_b = b; wr_rh = rh; wr_en = 1;
        @(posedge clk); #1 wr_en = 0;
    endtask

    task automatic run(input string n, input logic a, input logic b, input logic rh,
                       input int ef, input int ei, input int ee, input int el,
                       input bit hold, input bit sw);
        int lat;
        req_a = a; req_b = b; req_rh = rh; req_valid = 1;
        @(posedge clk); #1 req_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1 lat++;
        end
        chk({n, "_lat"}, lat, el);
        chk({n, "_found"}, rsp_found, ef);
        chk({n, "_idx"}, rsp_idx, ei);
        chk({n, "_exact"}, rsp_exact, ee);
        if (hold) begin
            req_a = 0; req_b = 0; req_rh = 0;
            repeat (5) begin
                req_valid = ~req_valid;
                @(posedge clk); #1;
            end
            req_valid = 0;
            chk({n, "_hold_valid"}, rsp_valid, 1);
            chk({n, "_hold_ready"}, req_ready, 0);
            chk({n, "_hold_idx"}, rsp_idx, ei);
        end
        if (sw) begin
            wr_idx = 3'd4; wr_vld = 1; wr_a = 0; wr_b = 1; wr_rh = 0; wr_en = 1;
        end
        rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0; wr_en = 0;
    endtask

    initial begin
        #3;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_inv_count", inv_count, 0);
        #9 rst_n = 1;
        @(posedge clk); #1;
        wr(0, 1, 1, 0, 1);
        wr(3, 1, 0, 0, 0);
        chk("load2_inv", inv_count, 2);
        run("o_pos", 0, 0, 1, 1, 3, 0, D + 4, 0, 0);
        chk("o_pos_consumed", inv_count, 1);
        wr(0, 0, 0, 0, 0);
        wr(2, 1, 1, 1, 1);
        wr(5, 1, 1, 1, 1);
        run("ab1", 1, 1, 1, 1, 2, 1, 3, 0, 0);
        run("ab2", 1, 1, 1, 1, 5, 1, 6, 0, 0);
        run("ab3", 1, 1, 1, 0, 0, 0, 2 * D, 0, 0);
        chk("ab_inv_empty", inv_count, 0);
        for (int i = 0; i < D; i++) wr(i, 1, 1, 0, 1);
        run("a_neg", 1, 0, 0, 0, 0, 0, 2 * D, 0, 0);
        chk("a_neg_all_valid", inv_count, D);
        run("hold", 1, 0, 1, 1, 0, 1, 1, 1, 0);
        for (int i = 1; i < 4; i++) wr(i, 0, 0, 0, 0);
        run("sw", 1, 0, 1, 1, 4, 1, 5, 0, 1);
        chk("sw_inv_kept", inv_count, 4);
        run("b_neg", 0, 1, 0, 1, 4, 1, 5, 0, 0);
        chk("b_neg_consumed", inv_count, 3);
        req_a = 0; req_b = 0; req_rh = 0; req_valid = 1;
        @(posedge clk); #1 req_valid = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_inv", inv_count, 0);
        chk("mid_rst_ready", req_ready, 1);
        rst_n = 1;
        @(posedge clk); #1;
        wr(1, 1, 0, 0, 1);
        run("after_rst", 0, 0, 1, 1, 1, 1, 2, 0, 0);
        repeat (2) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
